// File: rtl/pix_pkg.sv
// Shared definitions for the pixel pair stream generator.
//   - mode_e  : per-frame point operation selector
//   - state_e : frame sequencer states
//   - PIX_W / RGB_W / PAIR_W : channel, pixel and memory word widths
//   - sat_add / sat_sub : saturating 8-bit channel arithmetic
package pix_pkg;

    localparam int PIX_W  = 8;
    localparam int RGB_W  = 3 * PIX_W;
    localparam int PAIR_W = 48;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'd0,
        MODE_BRIGHT = 2'd1,
        MODE_INVERT = 2'd2,
        MODE_THRESH = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACTIVE = 3'd1,
        ST_HBLANK = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Clamp at 255: the carry out of the 9-bit sum signals overflow.
    function automatic logic [PIX_W-1:0] sat_add(input logic [PIX_W-1:0] c,
                                                 input logic [PIX_W-1:0] v);
        logic [PIX_W:0] sum;
        sum = {1'b0, c} + {1'b0, v};
        return sum[PIX_W] ? {PIX_W{1'b1}} : sum[PIX_W-1:0];
    endfunction

    // Clamp at 0: the sign bit of the 9-bit difference signals underflow.
    function automatic logic [PIX_W-1:0] sat_sub(input logic [PIX_W-1:0] c,
                                                 input logic [PIX_W-1:0] v);
        logic signed [PIX_W:0] diff;
        diff = $signed({1'b0, c}) - $signed({1'b0, v});
        return diff[PIX_W] ? {PIX_W{1'b0}} : diff[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/pix_point_op.sv
// Combinational point operation on one RGB888 pixel.
// Ports:
//   mode       : operation (pass / brightness / invert / threshold)
//   value      : brightness offset or threshold level
//   bright_sub : 1 = subtract value in brightness mode
//   pix_in     : {R,G,B}, R in the MSBs
//   pix_out    : processed {R,G,B}
module pix_point_op
    import pix_pkg::*;
(
    input  mode_e              mode,
    input  logic [PIX_W-1:0]   value,
    input  logic               bright_sub,
    input  logic [RGB_W-1:0]   pix_in,
    output logic [RGB_W-1:0]   pix_out
);

    // Threshold compares the channel sum against 3*value so no divide is
    // needed; both sides fit in 10 bits (max 765).
    logic [PIX_W+1:0] chan_sum;
    logic [PIX_W+1:0] thr3;
    logic             above;

    assign chan_sum = {2'b00, pix_in[RGB_W-1 -: PIX_W]}
                    + {2'b00, pix_in[RGB_W-1-PIX_W -: PIX_W]}
                    + {2'b00, pix_in[PIX_W-1:0]};
    assign thr3     = {2'b00, value} + {1'b0, value, 1'b0};
    assign above    = (chan_sum > thr3);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            logic [PIX_W-1:0] ch_in;
            logic [PIX_W-1:0] ch_out;

            assign ch_in = pix_in[RGB_W-1-gi*PIX_W -: PIX_W];

            always_comb begin
                ch_out = ch_in;
                case (mode)
                    MODE_PASS:   ch_out = ch_in;
                    MODE_BRIGHT: ch_out = bright_sub ? sat_sub(ch_in, value)
                                                     : sat_add(ch_in, value);
                    MODE_INVERT: ch_out = ~ch_in;
                    MODE_THRESH: ch_out = above ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
                    default:     ch_out = ch_in;
                endcase
            end

            assign pix_out[RGB_W-1-gi*PIX_W -: PIX_W] = ch_out;
        end
    endgenerate

endmodule

// File: rtl/pixel_pair_stream_gen.sv
// Frame source for the BMP writer. Walks a frame memory holding two RGB888
// pixels per word in top-down row order, applies one point operation to
// every pixel and presents one pair per hsync cycle.
// Ports:
//   HCLK, HRESETn      : clock, asynchronous active-low reset
//   start              : one-cycle frame request (ignored while busy)
//   mode/value/bright_sub : operation setup, captured on accepted start
//   mem_rd, mem_addr   : frame memory read strobe / word address
//   mem_rdata          : {R0,G0,B0,R1,G1,B1}, valid one cycle after mem_rd
//   hsync              : output pair valid
//   DATA_WRITE_*0/*1   : even / odd pixel of the pair, held while hsync=0
//   busy               : accepted start through frame_done inclusive
//   frame_done         : one-cycle pulse one cycle after the last pair
module pixel_pair_stream_gen
    import pix_pkg::*;
#(
    parameter int unsigned WIDTH      = 768,
    parameter int unsigned HEIGHT     = 512,
    parameter int unsigned ADDR_W     = 18,
    parameter int unsigned HBLANK_CYC = 4
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [7:0]          value,
    input  logic                bright_sub,
    output logic                mem_rd,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [PAIR_W-1:0]   mem_rdata,
    output logic                hsync,
    output logic [7:0]          DATA_WRITE_R0,
    output logic [7:0]          DATA_WRITE_G0,
    output logic [7:0]          DATA_WRITE_B0,
    output logic [7:0]          DATA_WRITE_R1,
    output logic [7:0]          DATA_WRITE_G1,
    output logic [7:0]          DATA_WRITE_B1,
    output logic                busy,
    output logic                frame_done
);

    localparam int unsigned COLS  = WIDTH / 2;
    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned HB_W  = (HBLANK_CYC > 1) ? $clog2(HBLANK_CYC) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
    // The blank counter counts down to zero, so it loads one less than the
    // number of blank cycles.
    localparam logic [HB_W-1:0]  HB_LOAD  = HB_W'((HBLANK_CYC > 0) ? HBLANK_CYC - 1 : 0);

    state_e              state_q,  state_d;
    logic [COL_W-1:0]    col_q,    col_d;
    logic [ROW_W-1:0]    row_q,    row_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [HB_W-1:0]     hb_cnt_q, hb_cnt_d;
    logic                fl_cnt_q, fl_cnt_d;
    mode_e               mode_q,   mode_d;
    logic [PIX_W-1:0]    value_q,  value_d;
    logic                sub_q,    sub_d;
    logic                rd_q,     rd_d;
    logic                hsync_q,  hsync_d;
    logic [PAIR_W-1:0]   data_q,   data_d;

    logic [RGB_W-1:0]    proc_pix [2];

    // Frame sequencer
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        addr_d   = addr_q;
        hb_cnt_d = hb_cnt_q;
        fl_cnt_d = fl_cnt_q;
        mode_d   = mode_q;
        value_d  = value_q;
        sub_d    = sub_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d  = mode_e'(mode);
                    value_d = value;
                    sub_d   = bright_sub;
                    col_d   = '0;
                    row_d   = '0;
                    addr_d  = '0;
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                // Address runs straight through row boundaries because rows
                // are stored back to back.
                addr_d = addr_q + ADDR_W'(1);
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    if (row_q == ROW_LAST) begin
                        fl_cnt_d = 1'b0;
                        state_d  = ST_FLUSH;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                        if (HBLANK_CYC > 0) begin
                            hb_cnt_d = HB_LOAD;
                            state_d  = ST_HBLANK;
                        end
                    end
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
            ST_HBLANK: begin
                if (hb_cnt_q == '0) begin
                    state_d = ST_ACTIVE;
                end else begin
                    hb_cnt_d = hb_cnt_q - HB_W'(1);
                end
            end
            ST_FLUSH: begin
                // Two idle cycles let the last read reach hsync.
                if (fl_cnt_q) begin
                    state_d = ST_DONE;
                end else begin
                    fl_cnt_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Two-stage output pipeline: rd_q marks the cycle mem_rdata is valid,
    // then the processed pair and hsync are registered together.
    always_comb begin
        rd_d    = (state_q == ST_ACTIVE);
        hsync_d = rd_q;
        data_d  = data_q;
        if (rd_q) begin
            data_d = {proc_pix[0], proc_pix[1]};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_pix
            pix_point_op u_op (
                .mode       (mode_q),
                .value      (value_q),
                .bright_sub (sub_q),
                .pix_in     (mem_rdata[PAIR_W-1-gi*RGB_W -: RGB_W]),
                .pix_out    (proc_pix[gi])
            );
        end
    endgenerate

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= ST_IDLE;
            col_q    <= '0;
            row_q    <= '0;
            addr_q   <= '0;
            hb_cnt_q <= '0;
            fl_cnt_q <= 1'b0;
            mode_q   <= MODE_PASS;
            value_q  <= '0;
            sub_q    <= 1'b0;
            rd_q     <= 1'b0;
            hsync_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            addr_q   <= addr_d;
            hb_cnt_q <= hb_cnt_d;
            fl_cnt_q <= fl_cnt_d;
            mode_q   <= mode_d;
            value_q  <= value_d;
            sub_q    <= sub_d;
            rd_q     <= rd_d;
            hsync_q  <= hsync_d;
            data_q   <= data_d;
        end
    end

    // Status outputs decode the state register directly so they drop the
    // moment reset is asserted.
    assign mem_rd     = (state_q == ST_ACTIVE);
    assign mem_addr   = addr_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_DONE);
    assign hsync      = hsync_q;

    assign DATA_WRITE_R0 = data_q[47:40];
    assign DATA_WRITE_G0 = data_q[39:32];
    assign DATA_WRITE_B0 = data_q[31:24];
    assign DATA_WRITE_R1 = data_q[23:16];
    assign DATA_WRITE_G1 = data_q[15:8];
    assign DATA_WRITE_B1 = data_q[7:0];

endmodule

// File: tb/tb_pixel_pair_stream_gen.sv
module tb_pixel_pair_stream_gen;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    int chk_cnt = 0;
    int pass_cnt = 0;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    // ---------------- instance A: 8x3, HBLANK 3 ----------------
    logic        a_start = 1'b0;
    logic [1:0]  a_mode = 2'd0;
    logic [7:0]  a_value = 8'd0;
    logic        a_sub = 1'b0;
    logic        a_mem_rd, a_hsync, a_busy, a_done;
    logic [3:0]  a_mem_addr;
    logic [47:0] a_rdata = '0;
    logic [7:0]  a_r0, a_g0, a_b0, a_r1, a_g1, a_b1;

    pixel_pair_stream_gen #(.WIDTH(8), .HEIGHT(3), .ADDR_W(4), .HBLANK_CYC(3)) dut_a (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(a_start), .mode(a_mode),
        .value(a_value), .bright_sub(a_sub), .mem_rd(a_mem_rd), .mem_addr(a_mem_addr),
        .mem_rdata(a_rdata), .hsync(a_hsync),
        .DATA_WRITE_R0(a_r0), .DATA_WRITE_G0(a_g0), .DATA_WRITE_B0(a_b0),
        .DATA_WRITE_R1(a_r1), .DATA_WRITE_G1(a_g1), .DATA_WRITE_B1(a_b1),
        .busy(a_busy), .frame_done(a_done)
    );

    logic [47:0] mem_a [16];
    always @(posedge HCLK) if (a_mem_rd) a_rdata <= mem_a[a_mem_addr];

    // ---------------- instance B: 8x2, no blanking ----------------
    logic        b_start = 1'b0;
    logic        b_mem_rd, b_hsync, b_busy, b_done;
    logic [2:0]  b_mem_addr;
    logic [47:0] b_rdata = '0;
    logic [7:0]  b_r0, b_g0, b_b0, b_r1, b_g1, b_b1;
    logic [7:0]  b_byte;

    pixel_pair_stream_gen #(.WIDTH(8), .HEIGHT(2), .ADDR_W(3), .HBLANK_CYC(0)) dut_b (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(b_start), .mode(2'd0),
        .value(8'd0), .bright_sub(1'b0), .mem_rd(b_mem_rd), .mem_addr(b_mem_addr),
        .mem_rdata(b_rdata), .hsync(b_hsync),
        .DATA_WRITE_R0(b_r0), .DATA_WRITE_G0(b_g0), .DATA_WRITE_B0(b_b0),
        .DATA_WRITE_R1(b_r1), .DATA_WRITE_G1(b_g1), .DATA_WRITE_B1(b_b1),
        .busy(b_busy), .frame_done(b_done)
    );

    assign b_byte = 8'(b_mem_addr);
    always @(posedge HCLK) if (b_mem_rd) b_rdata <= {6{b_byte}};

    // ---------------- expected values ----------------
    // Hand-computed results for the directed words 0..4
    // (brightness uses value 100, threshold uses value 128).
    function automatic logic [47:0] hand_exp(input int m, input bit sub, input int idx);
        logic [47:0] r;
        r = mem_a[idx];
        case (m)
            1: if (!sub) begin
                   case (idx)
                       0: r = 48'hFF6EFF_6EFF6E;   // 200+100 sat, 10+100=110
                       1: r = 48'h96FF96_FF96FF;
                       2: r = 48'h64FFBE_BEFF64;
                       3: r = 48'hE4E4E4_E5E4E4;
                       default: r = 48'hE5E4E4_E4E4E4;
                   endcase
               end else begin
                   case (idx)
                       0: r = 48'h640064_006400;
                       1: r = 48'h005000_500050;   // 50-100 -> 0, 180-100 = 80
                       2: r = 48'h009B00_009B00;
                       3: r = 48'h1C1C1C_1D1C1C;
                       default: r = 48'h1D1C1C_1C1C1C;
                   endcase
               end
            2: case (idx)
                   0: r = 48'h37F537_F537F5;
                   1: r = 48'hCD4BCD_4BCD4B;
                   2: r = 48'hFF00A5_A500FF;
                   3: r = 48'h7F7F7F_7E7F7F;
                   default: r = 48'h7E7F7F_7F7F7F;
               endcase
            3: case (idx)
                   0: r = 48'hFFFFFF_000000;   // 410 > 384, 220 <= 384
                   1: r = 48'h000000_FFFFFF;
                   2: r = 48'h000000_000000;
                   3: r = 48'h000000_FFFFFF;   // 384 not > 384, 385 > 384
                   default: r = 48'hFFFFFF_000000;
               endcase
            default: r = mem_a[idx];
        endcase
        return r;
    endfunction

    // Behavioural reference for the remaining words (integer arithmetic).
    function automatic logic [47:0] model_word(input int m, input int v, input bit sub,
                                              input logic [47:0] w);
        logic [47:0] r;
        int c [6];
        int o [6];
        for (int k = 0; k < 6; k++) c[k] = int'(w[47-8*k -: 8]);
        for (int k = 0; k < 6; k++) begin
            case (m)
                1: begin
                       o[k] = sub ? c[k] - v : c[k] + v;
                       if (o[k] > 255) o[k] = 255;
                       if (o[k] < 0) o[k] = 0;
                   end
                2: o[k] = 255 - c[k];
                3: begin
                       int s;
                       s = (k < 3) ? c[0] + c[1] + c[2] : c[3] + c[4] + c[5];
                       o[k] = (s > 3 * v) ? 255 : 0;
                   end
                default: o[k] = c[k];
            endcase
        end
        for (int k = 0; k < 6; k++) r[47-8*k -: 8] = 8'(o[k]);
        return r;
    endfunction

    // ---------------- monitor A ----------------
    logic [47:0] a_q [$];
    int          a_seen = 0;
    int          a_low = 0;
    int          a_exp_addr = 0;
    logic [47:0] a_act, a_exp, a_last = '0;

    always @(negedge HCLK) begin
        a_act = {a_r0, a_g0, a_b0, a_r1, a_g1, a_b1};
        if (HRESETn) begin
            if (a_mem_rd) begin
                check("a_mem_addr", 48'(a_mem_addr), 48'(a_exp_addr));
                a_exp_addr++;
            end
            if (a_hsync) begin
                if (a_seen > 0)
                    check("a_hsync_gap", 48'(a_low), (a_seen % 4 == 0) ? 48'd3 : 48'd0);
                if (a_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL a_unexpected_pair: got %h required no pair", a_act);
                end else begin
                    a_exp = a_q.pop_front();
                    check("a_pair", a_act, a_exp);
                end
                $display("A pair %0d: data %h", a_seen, a_act);
                a_last = a_act;
                a_seen++;
                a_low = 0;
            end else if (a_seen > 0) begin
                a_low++;
                check("a_hold", a_act, a_last);
            end
            if (a_done) begin
                check("a_done_after_last", 48'(a_low), 48'd1);
                check("a_pair_count", 48'(a_seen), 48'd12);
                check("a_busy_at_done", 48'(a_busy), 48'd1);
                check("a_queue_drained", 48'(a_q.size()), 48'd0);
            end
        end
    end

    // ---------------- monitor B ----------------
    int          b_cyc = 0;
    int          b_first_rd = 0;
    int          b_exp_addr = 0;
    int          b_seen = 0;
    int          b_low = 0;
    logic [7:0]  b_exp_byte;

    always @(negedge HCLK) begin
        b_cyc++;
        if (HRESETn) begin
            if (b_mem_rd) begin
                if (b_exp_addr == 0) b_first_rd = b_cyc;
                check("b_mem_addr", 48'(b_mem_addr), 48'(b_exp_addr));
                b_exp_addr++;
            end
            if (b_hsync) begin
                if (b_seen == 0) check("b_latency", 48'(b_cyc - b_first_rd), 48'd2);
                else check("b_back_to_back", 48'(b_low), 48'd0);
                b_exp_byte = 8'(b_seen);
                check("b_pair", {b_r0, b_g0, b_b0, b_r1, b_g1, b_b1}, {6{b_exp_byte}});
                $display("B pair %0d: data %h", b_seen, {b_r0, b_g0, b_b0, b_r1, b_g1, b_b1});
                b_seen++;
                b_low = 0;
            end else if (b_seen > 0) begin
                b_low++;
            end
            if (b_done) begin
                check("b_done_after_last", 48'(b_low), 48'd1);
                check("b_pair_count", 48'(b_seen), 48'd8);
                check("b_busy_at_done", 48'(b_busy), 48'd1);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic check_idle_a(input string tag);
        check({tag, "_mem_rd"}, 48'(a_mem_rd), 48'd0);
        check({tag, "_hsync"}, 48'(a_hsync), 48'd0);
        check({tag, "_busy"}, 48'(a_busy), 48'd0);
        check({tag, "_frame_done"}, 48'(a_done), 48'd0);
        check({tag, "_mem_addr"}, 48'(a_mem_addr), 48'd0);
        check({tag, "_data"}, {a_r0, a_g0, a_b0, a_r1, a_g1, a_b1}, 48'd0);
    endtask

    task automatic start_frame_a(input int m, input int v, input bit sub);
        for (int i = 0; i < 12; i++)
            a_q.push_back(i < 5 ? hand_exp(m, sub, i) : model_word(m, v, sub, mem_a[i]));
        a_exp_addr = 0;
        a_seen = 0;
        a_low = 0;
        @(posedge HCLK); #1;
        a_mode = 2'(m);
        a_value = 8'(v);
        a_sub = sub;
        a_start = 1'b1;
        @(posedge HCLK); #1;
        a_start = 1'b0;
    endtask

    task automatic wait_done_a(input string tag);
        bit got = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge HCLK); #1;
            if (a_done) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            chk_cnt++;
            $display("FAIL %s_timeout: got no frame_done required frame_done within 200 cycles", tag);
        end
        @(posedge HCLK); #1;
        check({tag, "_idle_after_done"}, 48'(a_busy), 48'd0);
    endtask

    task automatic wait_seen_a(input int n);
        for (int i = 0; i < 100; i++) begin
            @(posedge HCLK); #1;
            if (a_seen >= n) break;
        end
    endtask

    initial begin
        mem_a[0] = 48'hC80AC8_0AC80A;   // 200,10,200 / 10,200,10
        mem_a[1] = 48'h32B432_B432B4;   // 50,180,50 / 180,50,180
        mem_a[2] = 48'h00FF5A_5AFF00;
        mem_a[3] = 48'h808080_818080;   // threshold edge: even equal, odd above
        mem_a[4] = 48'h818080_808080;
        for (int n = 5; n < 16; n++) mem_a[n] = {6{8'(n * 17)}};

        HRESETn = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        check_idle_a("reset");
        check("b_reset_busy", 48'(b_busy), 48'd0);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        check_idle_a("after_reset");

        // Instance B: pass frame, back-to-back rows
        b_start = 1'b1;
        @(posedge HCLK); #1;
        b_start = 1'b0;
        begin
            bit got = 0;
            for (int i = 0; i < 100; i++) begin
                @(posedge HCLK); #1;
                if (b_done) begin got = 1; break; end
            end
            if (!got) begin
                chk_cnt++;
                $display("FAIL b_timeout: got no frame_done required frame_done within 100 cycles");
            end
        end
        @(posedge HCLK); #1;
        check("b_idle_after_done", 48'(b_busy), 48'd0);

        // Instance A: each operation over the directed words
        start_frame_a(0, 0, 0);   wait_done_a("a_pass");
        start_frame_a(1, 100, 0); wait_done_a("a_bright_add");
        start_frame_a(1, 100, 1); wait_done_a("a_bright_sub");
        start_frame_a(2, 0, 0);   wait_done_a("a_invert");
        start_frame_a(3, 128, 0); wait_done_a("a_thresh");

        // Start and setup changes during a frame must not disturb it
        start_frame_a(2, 0, 0);
        wait_seen_a(3);
        a_mode = 2'd0;
        a_value = 8'd7;
        a_start = 1'b1;
        @(posedge HCLK); #1;
        a_start = 1'b0;
        check("a_busy_after_ignored_start", 48'(a_busy), 48'd1);
        wait_done_a("a_ignored_start");

        // Asynchronous reset in the middle of a row
        start_frame_a(0, 0, 0);
        wait_seen_a(2);
        HRESETn = 1'b0;
        #1;
        check("mid_reset_hsync", 48'(a_hsync), 48'd0);
        check("mid_reset_mem_rd", 48'(a_mem_rd), 48'd0);
        check("mid_reset_busy", 48'(a_busy), 48'd0);
        a_q.delete();
        a_seen = 0;
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        check_idle_a("post_mid_reset");

        // Fresh frame after the reset restarts from address 0
        start_frame_a(1, 100, 0); wait_done_a("a_after_reset");

        check("a_final_queue_empty", 48'(a_q.size()), 48'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation time limit required $finish before it");
        $fatal(1, "watchdog expired");
    end

endmodule
